// File: rtl/vga_cpu_port.sv
// CPU-side access controller for the shared 4-bank video RAM: byte-lane decode, slot wait, CS/WE/transceiver sequencing.
// Latency: req (synchronized) to DONE = 1+SETUP_CLKS+WR_PULSE+1 clocks for writes, 1+SETUP_CLKS+2 for reads.
// Backpressure: rdy holds the CPU in wait states until DONE; RAM access waits for slot_free from the display timing block.
module vga_cpu_port #(
  parameter int WR_PULSE   = 2,
  parameter int SETUP_CLKS = 1,
  parameter int SLOT_MIN   = 4
) (
  input  logic       clock,
  input  logic       _reset,
  input  logic       _vga_mem,
  input  logic [1:0] addr,
  input  logic       _rd,
  input  logic       _wr,
  input  logic       _bhe,
  input  logic       slot_free,
  output logic       rdy,
  output logic [3:0] _cs_ram,
  output logic [3:0] _we_ram,
  output logic       _cpu_ram_addr,
  output logic [3:0] _cpu_ram,
  output logic       cpu_ram_dir,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } state_t;

  localparam logic [2:0] SETUP_LAST = 3'(SETUP_CLKS - 1);
  localparam logic [2:0] WR_LAST    = 3'(WR_PULSE - 1);

  // A display slot shorter than a full write would let the display fetch collide with our strobe.
  if (SLOT_MIN < SETUP_CLKS + WR_PULSE + 1) begin : g_slot_check
    $error("vga_cpu_port: SLOT_MIN must be >= SETUP_CLKS+WR_PULSE+1");
  end

  state_t     state;
  logic [2:0] cnt;
  logic [3:0] mask_q;
  logic       write_q;
  logic       abort_q;

  logic [1:0] mem_sync;
  logic [1:0] rd_sync;
  logic [1:0] wr_sync;
  logic       s_mem;
  logic       s_rd;
  logic       s_wr;
  logic       req;
  logic       write;
  logic [3:0] lane_mask;

  // Two-flop synchronizers for the raw CPU strobes; reset to the inactive level.
  always_ff @(posedge clock) begin
    if (!_reset) begin
      mem_sync <= 2'b11;
      rd_sync  <= 2'b11;
      wr_sync  <= 2'b11;
    end else begin
      mem_sync <= {mem_sync[0], _vga_mem};
      rd_sync  <= {rd_sync[0], _rd};
      wr_sync  <= {wr_sync[0], _wr};
    end
  end

  assign s_mem = mem_sync[1];
  assign s_rd  = rd_sync[1];
  assign s_wr  = wr_sync[1];
  assign req   = ~s_mem & (~s_rd | ~s_wr);
  assign write = ~s_wr;

  // 8086 lane decode: A1 picks the bank pair, A0=0 enables the low bank, BHE=0 the high bank.
  always_comb begin
    lane_mask = 4'b0000;
    if (addr[1]) begin
      lane_mask[2] = ~addr[0];
      lane_mask[3] = ~_bhe;
    end else begin
      lane_mask[0] = ~addr[0];
      lane_mask[1] = ~_bhe;
    end
  end

  // rdy works off the raw strobes so the CPU is stalled before the synchronizers have caught up.
  always_comb begin
    rdy = !((!_vga_mem) && (!_rd || !_wr) && (state != ST_DONE));
  end

  // Access sequencer; every RAM-side control is registered so it changes only on clock edges.
  always_ff @(posedge clock) begin
    if (!_reset) begin
      state         <= ST_IDLE;
      cnt           <= 3'd0;
      mask_q        <= 4'b0000;
      write_q       <= 1'b0;
      abort_q       <= 1'b0;
      _cs_ram       <= 4'b1111;
      _we_ram       <= 4'b1111;
      _cpu_ram      <= 4'b1111;
      _cpu_ram_addr <= 1'b1;
      cpu_ram_dir   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          abort_q <= 1'b0;
          cnt     <= 3'd0;
          if (req) begin
            mask_q  <= lane_mask;
            write_q <= write;
            // No lane selected: complete the bus cycle without touching the RAM.
            state   <= (lane_mask == 4'b0000) ? ST_DONE : ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (!req) begin
            state <= ST_IDLE;
          end else if (slot_free) begin
            state         <= ST_SETUP;
            cnt           <= 3'd0;
            busy          <= 1'b1;
            _cpu_ram_addr <= 1'b0;
            cpu_ram_dir   <= write_q;
            _cpu_ram      <= ~mask_q;
          end
        end

        ST_SETUP: begin
          if (!req) begin
            // Aborting before any strobe: release the bus without a CS pulse.
            state         <= ST_IDLE;
            busy          <= 1'b0;
            _cpu_ram_addr <= 1'b1;
            cpu_ram_dir   <= 1'b0;
            _cpu_ram      <= 4'b1111;
          end else if (cnt == SETUP_LAST) begin
            state   <= ST_STROBE;
            cnt     <= 3'd0;
            _cs_ram <= ~mask_q;
            _we_ram <= write_q ? ~mask_q : 4'b1111;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end

        ST_STROBE: begin
          // Once strobing, a dropped request is remembered but the pulse runs to completion.
          if (!req) begin
            abort_q <= 1'b1;
          end
          if (!write_q || cnt == WR_LAST) begin
            state   <= ST_HOLD;
            cnt     <= 3'd0;
            _we_ram <= 4'b1111;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end

        ST_HOLD: begin
          if (!req || abort_q) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            _cs_ram       <= 4'b1111;
            _cpu_ram      <= 4'b1111;
            _cpu_ram_addr <= 1'b1;
            cpu_ram_dir   <= 1'b0;
          end else begin
            state <= ST_DONE;
            // Writes are finished after the hold clock; reads keep driving until the CPU lets go.
            if (write_q) begin
              _cs_ram       <= 4'b1111;
              _cpu_ram      <= 4'b1111;
              _cpu_ram_addr <= 1'b1;
              cpu_ram_dir   <= 1'b0;
            end
          end
        end

        ST_DONE: begin
          if (s_mem || (s_rd && s_wr)) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            _cs_ram       <= 4'b1111;
            _cpu_ram      <= 4'b1111;
            _cpu_ram_addr <= 1'b1;
            cpu_ram_dir   <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_cpu_port.sv
// Directed bench for vga_cpu_port with default parameters (WR_PULSE=2, SETUP_CLKS=1).
// Outputs are packed as {rdy, _cs_ram, _we_ram, _cpu_ram_addr, _cpu_ram, cpu_ram_dir, busy}.
// Inputs change and outputs are sampled 2 time units after each rising edge.
module tb_vga_cpu_port;

  logic       clock = 1'b0;
  logic       _reset;
  logic       _vga_mem;
  logic [1:0] addr;
  logic       _rd;
  logic       _wr;
  logic       _bhe;
  logic       slot_free;
  logic       rdy;
  logic [3:0] _cs_ram;
  logic [3:0] _we_ram;
  logic       _cpu_ram_addr;
  logic [3:0] _cpu_ram;
  logic       cpu_ram_dir;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #10 clock = ~clock;

  vga_cpu_port #(.WR_PULSE(2), .SETUP_CLKS(1), .SLOT_MIN(4)) dut (
    .clock        (clock),
    ._reset       (_reset),
    ._vga_mem     (_vga_mem),
    .addr         (addr),
    ._rd          (_rd),
    ._wr          (_wr),
    ._bhe         (_bhe),
    .slot_free    (slot_free),
    .rdy          (rdy),
    ._cs_ram      (_cs_ram),
    ._we_ram      (_we_ram),
    ._cpu_ram_addr(_cpu_ram_addr),
    ._cpu_ram     (_cpu_ram),
    .cpu_ram_dir  (cpu_ram_dir),
    .busy         (busy)
  );

  function automatic logic [15:0] pk(input logic r, input logic [3:0] cs, input logic [3:0] we,
                                     input logic a, input logic [3:0] tr, input logic d,
                                     input logic b);
    return {r, cs, we, a, tr, d, b};
  endfunction

  function automatic logic [15:0] outs();
    return pk(rdy, _cs_ram, _we_ram, _cpu_ram_addr, _cpu_ram, cpu_ram_dir, busy);
  endfunction

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk(input string tag, input logic [15:0] exp);
    chk_v(tag, {16'h0, outs()}, {16'h0, exp});
  endtask

  initial begin
    logic [15:0] idle1;
    logic [15:0] idle0;
    int bad;
    idle1 = pk(1'b1, 4'hF, 4'hF, 1'b1, 4'hF, 1'b0, 1'b0);
    idle0 = pk(1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 1'b0, 1'b0);

    _reset = 1'b0; _vga_mem = 1'b1; addr = 2'b00; _rd = 1'b1; _wr = 1'b1;
    _bhe = 1'b1; slot_free = 1'b0;
    tick(); tick(); tick();
    chk("reset_state", idle1);
    _reset = 1'b1;
    tick();
    chk("after_reset", idle1);

    // Word write to banks 2/3: mask 1100, active-low 0011.
    addr = 2'b10; _bhe = 1'b0; slot_free = 1'b1; _vga_mem = 1'b0; _wr = 1'b0;
    #1 chk_v("ww_rdy_immediate", {31'h0, rdy}, 32'h0);
    tick(); chk("ww_sync1", idle0);
    tick(); chk("ww_sync2", idle0);
    tick(); chk("ww_wait", idle0);
    tick(); chk("ww_setup", pk(1'b0, 4'hF, 4'hF, 1'b0, 4'h3, 1'b1, 1'b1));
    tick(); chk("ww_strobe1", pk(1'b0, 4'h3, 4'h3, 1'b0, 4'h3, 1'b1, 1'b1));
    tick(); chk("ww_strobe2", pk(1'b0, 4'h3, 4'h3, 1'b0, 4'h3, 1'b1, 1'b1));
    tick(); chk("ww_hold", pk(1'b0, 4'h3, 4'hF, 1'b0, 4'h3, 1'b1, 1'b1));
    tick(); chk("ww_done", pk(1'b1, 4'hF, 4'hF, 1'b1, 4'hF, 1'b0, 1'b1));
    _wr = 1'b1; _vga_mem = 1'b1;
    tick(); chk("ww_rel1", pk(1'b1, 4'hF, 4'hF, 1'b1, 4'hF, 1'b0, 1'b1));
    tick(); chk("ww_rel2", pk(1'b1, 4'hF, 4'hF, 1'b1, 4'hF, 1'b0, 1'b1));
    tick(); chk("ww_idle", idle1);
    tick();

    // Byte read of the high lane at addr 01: mask 0010, active-low 1101.
    addr = 2'b01; _bhe = 1'b0; _vga_mem = 1'b0; _rd = 1'b0;
    tick(); chk("rd_sync1", idle0);
    tick(); chk("rd_sync2", idle0);
    tick(); chk("rd_wait", idle0);
    tick(); chk("rd_setup", pk(1'b0, 4'hF, 4'hF, 1'b0, 4'hD, 1'b0, 1'b1));
    tick(); chk("rd_strobe", pk(1'b0, 4'hD, 4'hF, 1'b0, 4'hD, 1'b0, 1'b1));
    tick(); chk("rd_hold", pk(1'b0, 4'hD, 4'hF, 1'b0, 4'hD, 1'b0, 1'b1));
    tick(); chk("rd_done", pk(1'b1, 4'hD, 4'hF, 1'b0, 4'hD, 1'b0, 1'b1));
    tick(); chk("rd_done_hold", pk(1'b1, 4'hD, 4'hF, 1'b0, 4'hD, 1'b0, 1'b1));
    _rd = 1'b1;
    tick(); chk("rd_rel1", pk(1'b1, 4'hD, 4'hF, 1'b0, 4'hD, 1'b0, 1'b1));
    tick(); chk("rd_rel2", pk(1'b1, 4'hD, 4'hF, 1'b0, 4'hD, 1'b0, 1'b1));
    tick(); chk("rd_idle", idle1);
    _vga_mem = 1'b1;
    tick();

    // Write to bank 0 only while the display keeps the RAM for 100 clocks.
    addr = 2'b00; _bhe = 1'b1; slot_free = 1'b0; _vga_mem = 1'b0; _wr = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (outs() !== idle0) bad++;
    end
    chk_v("slot_wait_quiet_cycles", bad, 0);
    slot_free = 1'b1;
    tick(); chk("sw_setup", pk(1'b0, 4'hF, 4'hF, 1'b0, 4'hE, 1'b1, 1'b1));
    tick(); chk("sw_strobe1", pk(1'b0, 4'hE, 4'hE, 1'b0, 4'hE, 1'b1, 1'b1));
    tick(); chk("sw_strobe2", pk(1'b0, 4'hE, 4'hE, 1'b0, 4'hE, 1'b1, 1'b1));
    tick(); chk("sw_hold", pk(1'b0, 4'hE, 4'hF, 1'b0, 4'hE, 1'b1, 1'b1));
    tick(); chk("sw_done", pk(1'b1, 4'hF, 4'hF, 1'b1, 4'hF, 1'b0, 1'b1));
    _wr = 1'b1; _vga_mem = 1'b1;
    tick(); tick(); tick();
    chk("sw_idle", idle1);
    tick();

    // Empty lane mask (A0=1, BHE=1): DONE without any RAM activity.
    addr = 2'b01; _bhe = 1'b1; _vga_mem = 1'b0; _wr = 1'b0;
    tick(); chk("inv_sync1", idle0);
    tick(); chk("inv_sync2", idle0);
    tick(); chk("inv_done", idle1);
    tick(); chk("inv_done2", idle1);
    _wr = 1'b1; _vga_mem = 1'b1;
    tick(); tick(); tick();
    chk("inv_idle", idle1);

    // Abort while waiting for a slot: no pulse even once the slot opens.
    addr = 2'b00; _bhe = 1'b0; slot_free = 1'b0; _vga_mem = 1'b0; _wr = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk("abw_waiting", idle0);
    _vga_mem = 1'b1;
    tick(); chk("abw_rel1", idle1);
    tick(); chk("abw_rel2", idle1);
    tick(); chk("abw_rel3", idle1);
    slot_free = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (outs() !== idle1) bad++;
    end
    chk_v("abw_no_pulse_cycles", bad, 0);
    _wr = 1'b1;
    tick();

    // Abort during the write strobe: the 2-clock WE pulse still completes.
    addr = 2'b10; _bhe = 1'b0; slot_free = 1'b1; _vga_mem = 1'b0; _wr = 1'b0;
    tick(); tick(); tick();
    tick(); chk("abs_setup", pk(1'b0, 4'hF, 4'hF, 1'b0, 4'h3, 1'b1, 1'b1));
    tick(); chk("abs_strobe1", pk(1'b0, 4'h3, 4'h3, 1'b0, 4'h3, 1'b1, 1'b1));
    _vga_mem = 1'b1;
    tick(); chk("abs_strobe2", pk(1'b1, 4'h3, 4'h3, 1'b0, 4'h3, 1'b1, 1'b1));
    tick(); chk("abs_hold", pk(1'b1, 4'h3, 4'hF, 1'b0, 4'h3, 1'b1, 1'b1));
    tick(); chk("abs_idle", idle1);
    tick(); chk("abs_idle2", idle1);
    _wr = 1'b1;
    tick();

    // Reset on the second WE clock of a write to banks 0/1 (active-low 1100).
    addr = 2'b00; _bhe = 1'b0; slot_free = 1'b1; _vga_mem = 1'b0; _wr = 1'b0;
    tick(); tick(); tick();
    tick(); chk("rst_setup", pk(1'b0, 4'hF, 4'hF, 1'b0, 4'hC, 1'b1, 1'b1));
    tick(); chk("rst_strobe1", pk(1'b0, 4'hC, 4'hC, 1'b0, 4'hC, 1'b1, 1'b1));
    tick(); chk("rst_strobe2", pk(1'b0, 4'hC, 4'hC, 1'b0, 4'hC, 1'b1, 1'b1));
    _reset = 1'b0; _vga_mem = 1'b1; _wr = 1'b1;
    tick(); chk("rst_applied", idle1);
    _reset = 1'b1;
    tick(); chk("rst_released", idle1);
    tick(); chk("rst_settled", idle1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
